// File: rtl/alu_uart_interface_if.sv
//------------------------------------------------------------------------------
// alu_uart_interface_if
// Bundles the uart_rx / uart_tx / ALU signals seen by alu_uart_interface.
//   slave  : device side (the protocol engine) - consumes i_*, drives o_*
//   master : environment side (uart_rx, uart_tx, ALU) - drives i_*, consumes o_*
// Signals:
//   i_rx_done, i_rx_data      received byte flag (level or pulse) and data
//   i_tx_done                 uart_tx frame-done flag
//   i_alu_result              combinational ALU result
//   o_data_a, o_data_b, o_op  ALU operand / opcode registers
//   o_tx_start, o_tx_data     transmit launch pulse and byte
//   o_busy, o_timeout         status flags
//------------------------------------------------------------------------------
interface alu_uart_interface_if #(
   parameter int NB_DATA   = 8,
   parameter int N_BITS_OP = 6
);
   logic                 i_rx_done;
   logic [NB_DATA-1:0]   i_rx_data;
   logic                 i_tx_done;
   logic [NB_DATA-1:0]   i_alu_result;
   logic [NB_DATA-1:0]   o_data_a;
   logic [NB_DATA-1:0]   o_data_b;
   logic [N_BITS_OP-1:0] o_op;
   logic                 o_tx_start;
   logic [NB_DATA-1:0]   o_tx_data;
   logic                 o_busy;
   logic                 o_timeout;

   modport slave (
      input  i_rx_done, i_rx_data, i_tx_done, i_alu_result,
      output o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy, o_timeout
   );

   modport master (
      output i_rx_done, i_rx_data, i_tx_done, i_alu_result,
      input  o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy, o_timeout
   );
endinterface

// File: rtl/alu_uart_interface.sv
//------------------------------------------------------------------------------
// alu_uart_interface
// Protocol engine between uart_rx/uart_tx and an ALU. Collects operand A,
// operand B and opcode bytes, presents them to the ALU, latches the result and
// launches exactly one uart_tx frame carrying it. An inter-byte timeout drops a
// partial command and resynchronises to operand A.
// Ports:
//   i_clk    system clock (rising edge)
//   i_reset  synchronous active-high reset
//   bus      alu_uart_interface_if.slave (rx/tx flags, ALU result, outputs)
//------------------------------------------------------------------------------
module alu_uart_interface #(
   parameter int NB_DATA     = 8,
   parameter int N_BITS_OP   = 6,
   parameter int TIMEOUT_CYC = 1000000
) (
   input logic                 i_clk,
   input logic                 i_reset,
   alu_uart_interface_if.slave bus
);
   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {
      ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP, ST_EXEC, ST_SEND, ST_WAIT_TX
   } state_t;

   state_t               r_state;
   logic                 r_rx_q;
   logic                 r_tx_q;
   logic [CW-1:0]        r_cnt;
   logic [NB_DATA-1:0]   r_data_a;
   logic [NB_DATA-1:0]   r_data_b;
   logic [N_BITS_OP-1:0] r_op;
   logic                 r_tx_start;
   logic [NB_DATA-1:0]   r_tx_data;
   logic                 r_busy;
   logic                 r_timeout;

   // Flags may be levels; only rising edges count as new bytes / frames.
   logic w_rx_evt;
   logic w_tx_evt;
   logic w_cnt_hit;

   assign w_rx_evt  = bus.i_rx_done & ~r_rx_q;
   assign w_tx_evt  = bus.i_tx_done & ~r_tx_q;
   assign w_cnt_hit = (r_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_WAIT_A;
         // History high: a flag already asserted at reset release is stale.
         r_rx_q     <= 1'b1;
         r_tx_q     <= 1'b1;
         r_cnt      <= '0;
         r_data_a   <= '0;
         r_data_b   <= '0;
         r_op       <= '0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_rx_q     <= bus.i_rx_done;
         r_tx_q     <= bus.i_tx_done;
         r_tx_start <= 1'b0;
         r_timeout  <= 1'b0;
         case (r_state)
            ST_WAIT_A: begin
               r_cnt <= '0;
               if (w_rx_evt) begin
                  r_data_a <= bus.i_rx_data;
                  r_state  <= ST_WAIT_B;
                  r_busy   <= 1'b1;
               end
            end
            ST_WAIT_B: begin
               // An arriving byte beats a simultaneous timeout.
               if (w_rx_evt) begin
                  r_data_b <= bus.i_rx_data;
                  r_state  <= ST_WAIT_OP;
                  r_cnt    <= '0;
               end else if (w_cnt_hit) begin
                  r_state   <= ST_WAIT_A;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_WAIT_OP: begin
               if (w_rx_evt) begin
                  r_op    <= bus.i_rx_data[N_BITS_OP-1:0];
                  r_state <= ST_EXEC;
                  r_cnt   <= '0;
               end else if (w_cnt_hit) begin
                  r_state   <= ST_WAIT_A;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_EXEC: begin
               // r_op was updated last edge, so the ALU output has settled.
               r_cnt      <= '0;
               r_tx_data  <= bus.i_alu_result;
               r_tx_start <= 1'b1;
               r_state    <= ST_SEND;
            end
            ST_SEND: begin
               r_cnt   <= '0;
               r_state <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               // Bytes arriving here are dropped; the host must await the result.
               r_cnt <= '0;
               if (w_tx_evt) begin
                  r_state <= ST_WAIT_A;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= ST_WAIT_A;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_data_a   = r_data_a;
   assign bus.o_data_b   = r_data_b;
   assign bus.o_op       = r_op;
   assign bus.o_tx_start = r_tx_start;
   assign bus.o_tx_data  = r_tx_data;
   assign bus.o_busy     = r_busy;
   assign bus.o_timeout  = r_timeout;
endmodule
